// File: rtl/branch_predictor.sv
// Gshare branch direction predictor.
// D stage: combinational prediction from pc_D XOR global history.
// EX stage: trains the 2-bit counter selected by the index carried down the
// pipe, shifts the resolved outcome into the history, and counts branches
// and mispredictions.
module branch_predictor #(
    parameter int INDEX_W = 10,
    parameter int HIST_W  = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        pc_D,
    input  logic               branch_D,
    output logic               pred_take_D,
    output logic [INDEX_W-1:0] pred_index_D,
    input  logic               branch_E,
    input  logic               stall_E,
    input  logic [INDEX_W-1:0] pred_index_E,
    input  logic               actual_take_E,
    input  logic               pre_right_E,
    output logic [31:0]        branch_cnt,
    output logic [31:0]        mispred_cnt
);

    localparam int PHT_SIZE = 1 << INDEX_W;

    // Counter encoding: SNT=00, WNT=01, WT=10, ST=11; bit [1] is the guess.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic [1:0]         pht_r [PHT_SIZE];
    logic [HIST_W-1:0]  ghr_r;
    logic [31:0]        branch_cnt_r;
    logic [31:0]        mispred_cnt_r;

    logic               upd_s;
    logic [INDEX_W-1:0] idx_s;
    logic [1:0]         ctr_rd_s;
    logic [1:0]         ctr_new_s;
    logic [HIST_W-1:0]  ghr_next_s;
    logic [HIST_W:0]    ghr_ext_s;
    logic               unused_pc_s;

    // One saturating step of a 2-bit counter toward ST (taken) or SNT.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (ctr == CTR_ST) begin
                res = CTR_ST;
            end else begin
                res = ctr + 2'b01;
            end
        end else begin
            if (ctr == CTR_SNT) begin
                res = CTR_SNT;
            end else begin
                res = ctr - 2'b01;
            end
        end
        return res;
    endfunction

    // PC bits outside the index window do not affect the prediction.
    assign unused_pc_s = ^{pc_D[31:INDEX_W+2], pc_D[1:0]};

    // D-stage index and lookup; always uses the pre-update table and history.
    always_comb begin
        idx_s        = pc_D[INDEX_W+1:2] ^ INDEX_W'(ghr_r);
        ctr_rd_s     = pht_r[idx_s];
        pred_index_D = idx_s;
        pred_take_D  = branch_D & ctr_rd_s[1];
    end

    // EX-stage training controls: counter next value and shifted history.
    always_comb begin
        upd_s      = branch_E & ~stall_E;
        ctr_new_s  = ctr_step(pht_r[pred_index_E], actual_take_E);
        ghr_ext_s  = {ghr_r, actual_take_E};
        ghr_next_s = ghr_ext_s[HIST_W-1:0];
    end

    // Pattern history table: all weakly-not-taken on reset, one step per update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht_r[i] <= CTR_WNT;
            end
        end else if (upd_s) begin
            pht_r[pred_index_E] <= ctr_new_s;
        end
    end

    // Non-speculative global history, updated only at resolution.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ghr_r <= '0;
        end else if (upd_s) begin
            ghr_r <= ghr_next_s;
        end
    end

    // Branch and misprediction statistics, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt_r  <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else if (upd_s) begin
            branch_cnt_r <= branch_cnt_r + 32'd1;
            if (!pre_right_E) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_r;
    assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (INDEX_W=10, HIST_W=8).
// A table of per-cycle vectors covers reset state, training and counter
// hysteresis; hand-written sequences cover history shift, stall, same-cycle
// hazard, counter wrap and asynchronous reset.
module tb_branch_predictor;

    localparam int IW = 10;
    localparam int HW = 8;

    logic          clk;
    logic          resetn;
    logic [31:0]   pc_D;
    logic          branch_D;
    logic          pred_take_D;
    logic [IW-1:0] pred_index_D;
    logic          branch_E;
    logic          stall_E;
    logic [IW-1:0] pred_index_E;
    logic          actual_take_E;
    logic          pre_right_E;
    logic [31:0]   branch_cnt;
    logic [31:0]   mispred_cnt;

    int n_cmp;
    int n_fail;

    branch_predictor #(.INDEX_W(IW), .HIST_W(HW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pc_D         (pc_D),
        .branch_D     (branch_D),
        .pred_take_D  (pred_take_D),
        .pred_index_D (pred_index_D),
        .branch_E     (branch_E),
        .stall_E      (stall_E),
        .pred_index_E (pred_index_E),
        .actual_take_E(actual_take_E),
        .pre_right_E  (pre_right_E),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          be;
        logic          st;
        logic [IW-1:0] pie;
        logic          at;
        logic          pr;
        logic [31:0]   pc;
        logic          bd;
        logic          exp_take;
        logic [IW-1:0] exp_idx;
        logic [31:0]   exp_b;
        logic [31:0]   exp_m;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic be, input logic st, input logic [IW-1:0] pie,
                                input logic at, input logic pr, input logic [31:0] pc,
                                input logic bd, input logic et, input logic [IW-1:0] ei,
                                input logic [31:0] eb, input logic [31:0] em);
        vec_t v;
        v.be = be; v.st = st; v.pie = pie; v.at = at; v.pr = pr;
        v.pc = pc; v.bd = bd; v.exp_take = et; v.exp_idx = ei;
        v.exp_b = eb; v.exp_m = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic et, input logic [IW-1:0] ei,
                             input logic [31:0] eb, input logic [31:0] em);
        check({tag, " pred_take"},  {31'd0, pred_take_D}, {31'd0, et});
        check({tag, " pred_index"}, {22'd0, pred_index_D}, {22'd0, ei});
        check({tag, " branch_cnt"}, branch_cnt, eb);
        check({tag, " mispred_cnt"}, mispred_cnt, em);
    endtask

    // Drive EX inputs at a falling edge; they act on the following rising edge.
    task automatic cyc(input logic be, input logic st, input logic [IW-1:0] pie,
                       input logic at, input logic pr);
        @(negedge clk);
        branch_E = be; stall_E = st; pred_index_E = pie;
        actual_take_E = at; pre_right_E = pr;
    endtask

    task automatic set_d(input logic [31:0] pc, input logic bd);
        pc_D = pc; branch_D = bd;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        branch_E = 1'b0; stall_E = 1'b0;
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        resetn = 1'b0;
        set_d(32'd0, 1'b0);
        branch_E = 1'b0; stall_E = 1'b0; pred_index_E = '0;
        actual_take_E = 1'b0; pre_right_E = 1'b0;

        //            be    st    pie     at    pr    pc            bd    take  idx     b      m
        vecs[0]  = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0040_0010, 1'b1, 1'b0, 10'h004, 32'd0,  32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0040_0010, 1'b0, 1'b0, 10'h004, 32'd0,  32'd0);
        vecs[2]  = mk(1'b1, 1'b0, 10'h004, 1'b1, 1'b0, 32'h0040_0014, 1'b1, 1'b0, 10'h005, 32'd0,  32'd0);
        vecs[3]  = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0040_0014, 1'b1, 1'b1, 10'h004, 32'd1,  32'd1);
        vecs[4]  = mk(1'b1, 1'b0, 10'h007, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h001, 32'd1,  32'd1);
        vecs[5]  = mk(1'b1, 1'b0, 10'h007, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h003, 32'd2,  32'd1);
        vecs[6]  = mk(1'b1, 1'b0, 10'h007, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h007, 32'd3,  32'd1);
        vecs[7]  = mk(1'b1, 1'b0, 10'h007, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 10'h00F, 32'd4,  32'd1);
        vecs[8]  = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0060, 1'b1, 1'b1, 10'h007, 32'd5,  32'd1);
        vecs[9]  = mk(1'b1, 1'b0, 10'h007, 1'b0, 1'b0, 32'h0000_0060, 1'b1, 1'b1, 10'h007, 32'd5,  32'd1);
        vecs[10] = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_00E4, 1'b1, 1'b1, 10'h007, 32'd6,  32'd2);
        vecs[11] = mk(1'b1, 1'b0, 10'h007, 1'b0, 1'b0, 32'h0000_00E4, 1'b1, 1'b1, 10'h007, 32'd6,  32'd2);
        vecs[12] = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_01EC, 1'b1, 1'b0, 10'h007, 32'd7,  32'd3);
        vecs[13] = mk(1'b1, 1'b0, 10'h007, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h07C, 32'd7,  32'd3);
        vecs[14] = mk(1'b1, 1'b0, 10'h007, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h0F8, 32'd8,  32'd3);
        vecs[15] = mk(1'b1, 1'b0, 10'h007, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h0F0, 32'd9,  32'd3);
        vecs[16] = mk(1'b1, 1'b0, 10'h007, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h0E0, 32'd10, 32'd3);
        vecs[17] = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0318, 1'b1, 1'b0, 10'h007, 32'd11, 32'd4);
        vecs[18] = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0000_0314, 1'b1, 1'b1, 10'h004, 32'd11, 32'd4);

        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Table: reset state, first training, saturation and hysteresis.
        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].be, vecs[i].st, vecs[i].pie, vecs[i].at, vecs[i].pr);
            set_d(vecs[i].pc, vecs[i].bd);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_take, vecs[i].exp_idx,
                      vecs[i].exp_b, vecs[i].exp_m);
        end

        // History shift: T, N, T -> 0x05, then eight taken -> 0xFF.
        pulse_reset();
        cyc(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        set_d(32'h0000_0000, 1'b1);
        #1;
        check_all("ghr_05", 1'b0, 10'h005, 32'd3, 32'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b1);
        end
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        set_d(32'h0040_0000, 1'b1);
        #1;
        check_all("ghr_ff", 1'b0, 10'h0FF, 32'd11, 32'd0);

        // Stall: three stalled cycles do nothing, the unstalled one trains once.
        pulse_reset();
        cyc(1'b1, 1'b1, 10'h004, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 10'h004, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 10'h004, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 10'h004, 1'b1, 1'b1);
        set_d(32'h0040_0010, 1'b1);
        #1;
        check_all("stall_held", 1'b0, 10'h004, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        set_d(32'h0040_0014, 1'b1);
        #1;
        check_all("stall_once", 1'b1, 10'h004, 32'd1, 32'd0);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        #1;
        check("stall_no_extra branch_cnt", branch_cnt, 32'd1);

        // Same-cycle read and write of index 0x004: no bypass.
        pulse_reset();
        cyc(1'b1, 1'b0, 10'h004, 1'b1, 1'b1);
        set_d(32'h0040_0010, 1'b1);
        #1;
        check_all("hazard_same", 1'b0, 10'h004, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        set_d(32'h0040_0014, 1'b1);
        #1;
        check_all("hazard_next", 1'b1, 10'h004, 32'd1, 32'd0);

        // Misprediction counter wrap from 0xFFFF_FFFF.
        @(negedge clk);
        force dut.mispred_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_cnt_r;
        #1;
        check("wrap preload mispred_cnt", mispred_cnt, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 10'h010, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        set_d(32'h0040_001C, 1'b1);
        #1;
        check_all("wrap", 1'b1, 10'h004, 32'd2, 32'd0);

        // Asynchronous reset between edges clears everything at once.
        #1;
        resetn = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 10'h007, 32'd0, 32'd0);
        set_d(32'h0040_0010, 1'b1);
        #1;
        check_all("async_rst_pht", 1'b0, 10'h004, 32'd0, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check_all("after_rst", 1'b0, 10'h004, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Gshare direction predictor for the branch unit of the 5-stage MIPS pipeline. In D it supplies the taken/not-taken guess that travels down the pipe as `pred_take` and is compared against the real outcome in EX. In EX it is trained with the resolved outcome and the `pre_right` flag, and it keeps branch and misprediction statistics.

## Interface
- `INDEX_W`, 10: PHT index width; the table has 2^INDEX_W 2-bit counters.
- `HIST_W`, 8: global history register (GHR) width; must satisfy 1 ≤ HIST_W ≤ INDEX_W.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pc_D` in 32: PC of the instruction in D.
- `branch_D` in 1: the instruction in D is a conditional branch.
- `pred_take_D` out 1: predicted direction for the instruction in D.
- `pred_index_D` out INDEX_W: PHT index used for this prediction; pipelined to EX alongside the branch.
- `branch_E` in 1: a conditional branch is resolving in EX this cycle.
- `stall_E` in 1: EX is stalled; training is inhibited.
- `pred_index_E` in INDEX_W: the `pred_index_D` value carried with the resolving branch.
- `actual_take_E` in 1: resolved direction.
- `pre_right_E` in 1: the prediction matched the resolved direction.
- `branch_cnt` out 32: number of branches trained.
- `mispred_cnt` out 32: number of mispredictions trained.

## Operation
- **PHT.** 2^INDEX_W 2-bit saturating counters.
  - States: SNT=00, WNT=01, WT=10, ST=11.
  - The prediction is counter bit [1].
- **Index.** `idx = pc_D[INDEX_W+1:2] ^ {{(INDEX_W-HIST_W){1'b0}}, ghr}`. The GHR XORs into the low HIST_W bits only.
- **Prediction.** Combinational, no state change.
  - `pred_index_D = idx`, regardless of `branch_D`.
  - `pred_take_D = branch_D & pht[idx][1]`.
- **Training.** Enabled when `upd = branch_E & ~stall_E`. On each rising edge with `upd=1`:
  - `pht[pred_index_E]` steps one state toward ST if `actual_take_E=1`, or toward SNT if it is 0. It saturates at 11 and 00.
  - The GHR shifts in the outcome: `ghr <= {ghr[HIST_W-2:0], actual_take_E}`. If HIST_W=1, `ghr <= actual_take_E`.
  - `branch_cnt` increments by 1.
  - `mispred_cnt` increments by 1 when `pre_right_E=0`.
  - Both statistics counters wrap modulo 2^32.
- **No update.** With `upd=0`, nothing changes. `actual_take_E` and `pre_right_E` are don't-care.
- **GHR policy.** The GHR is non-speculative: it is updated only at resolution, never at prediction. Training uses the carried `pred_index_E`, never a recomputed index, so intervening GHR changes cannot misdirect the update.
- **Reset.** While `resetn=0`, asynchronously:
  - every PHT entry = WNT (01);
  - `ghr` = 0;
  - `branch_cnt` = 0 and `mispred_cnt` = 0.
  - Consequently `pred_take_D` = 0 for any PC.
  - A reset asserted mid-run discards all training immediately, with no clock edge required.

## Timing
- Prediction latency is 0 cycles: a combinational read from `pc_D`, `branch_D` and current state.
- Training latency is 1 cycle: state updates on the edge ending the cycle where `upd=1`. New values are visible to D and on the count outputs in the following cycle.
- Same-cycle read and write of the same index: D sees the pre-update counter, with no bypass. The new value appears from the next cycle.
- Same-cycle GHR use: a D prediction computes its index with the pre-shift GHR.
- Holding `stall_E=1` with `branch_E=1` for N cycles trains exactly once, on the first edge after `stall_E` falls.
- Deassertion of `resetn` is synchronised externally. The first training edge is the first rising edge with `resetn=1` and `upd=1`.

## Test plan
All scenarios use INDEX_W=10, HIST_W=8.

1. **Reset state.** Reset, then `pc_D=0x0040_0010`, `branch_D=1` → `pred_index_D=0x004`, `pred_take_D=0`. With `branch_D=0` → `pred_take_D=0`, `pred_index_D` still 0x004.
2. **Single taken update.** `upd` with `pred_index_E=0x004`, `actual_take_E=1`, `pre_right_E=0`. Next cycle: `ghr=0x01`, `branch_cnt=1`, `mispred_cnt=1`. `pc_D=0x0040_0014` gives `pred_index_D=0x004` and `pred_take_D=1`.
3. **Saturation / hysteresis on index 0x007.**
   - Four taken updates → ST.
   - One not-taken → WT, prediction still 1.
   - Second not-taken → WNT, prediction 0.
   - Three more not-taken → SNT. One taken → WNT, prediction 0.
4. **GHR shift.** From reset, train T, N, T → `ghr=0x05`. Then 8 further taken → `ghr=0xFF`, and `pc_D=0x0040_0000` gives `pred_index_D=0x0FF`.
5. **Stall and same-cycle hazard.**
   - `branch_E=1`, `stall_E=1` for 3 cycles, then `stall_E=0` for 1 cycle → exactly one counter step, `branch_cnt=1`.
   - Same cycle: D reads index 0x004 while EX trains 0x004 taken → D sees 0 that cycle and 1 the next.
6. **Counter wrap and async reset.**
   - Force `mispred_cnt` to 0xFFFF_FFFF, then one mispredict → 0x0000_0000.
   - Pulse `resetn` low between edges after training → all outputs return to reset values before the next edge.
